// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with run-time pattern load, selectable
// overlap mode and optional saturating match counter (enabled by SEQ_DET_COUNT_EN).
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap,
  input  logic             x_valid,
  input  logic             x,
  output logic             z,
  output logic             armed,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  shifted;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              z_q, z_d;
  logic              hit;

  always_comb begin
    shifted = {hist_q[PAT_W-2:0], x};
    // fill gating keeps the cleared history from producing false matches
    hit     = (state_q == RUN) && x_valid && !load &&
              (fill_q >= FILL_THR) && (shifted == pat_q);
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    z_d     = 1'b0;
    if (load) begin
      state_d = RUN;
      pat_d   = pattern_in;
      hist_d  = '0;
      fill_d  = '0;
    end else if (state_q == RUN && x_valid) begin
      hist_d = shifted;
      z_d    = hit;
      if (hit && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hist_q  <= '0;
      pat_q   <= '0;
      fill_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      z_q     <= z_d;
    end
  end

  assign z     = z_q;
  assign armed = (state_q == RUN);

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
  assign count_sat   = &cnt_q;
`else
  assign match_count = '0;
  assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: vector table, directed corner
// sequences and randomized stimulus against a bit-queue reference model.
module tb_seq_detector_param;

  localparam int PW = 4;
`ifdef SEQ_DET_COUNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load = 1'b0;
  logic [PW-1:0] pattern_in = '0;
  logic          overlap = 1'b0;
  logic          x_valid = 1'b0;
  logic          x = 1'b0;

  logic          z_a, armed_a, sat_a;
  logic [7:0]    cnt_a;
  logic          z_b, armed_b, sat_b;
  logic [1:0]    cnt_b;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(PW), .CNT_W(8)) u_a (
    .clk(clk), .reset_n(reset_n), .load(load), .pattern_in(pattern_in),
    .overlap(overlap), .x_valid(x_valid), .x(x),
    .z(z_a), .armed(armed_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detector_param #(.PAT_W(PW), .CNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .load(load), .pattern_in(pattern_in),
    .overlap(overlap), .x_valid(x_valid), .x(x),
    .z(z_b), .armed(armed_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  // Reference model: the valid bits received since load (or since the last
  // non-overlapping match); a match is "the last PW bits equal the pattern".
  bit            m_armed;
  bit            m_z;
  logic [PW-1:0] m_pat;
  bit            m_q[$];
  int            m_cnt_a, m_cnt_b;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit            ld;
    logic [PW-1:0] pat;
    bit            ov;
    bit            xv;
    bit            xb;
    bit            ez;
    int            ecnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic bit tail_hit();
    logic [PW-1:0] v;
    if (m_q.size() < PW) return 1'b0;
    for (int i = 0; i < PW; i++) v[PW-1-i] = m_q[m_q.size()-PW+i];
    return v == m_pat;
  endfunction

  task automatic model_reset();
    m_armed = 1'b0; m_z = 1'b0; m_pat = '0; m_q.delete();
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_edge();
    bit hit;
    if (load) begin
      m_armed = 1'b1; m_pat = pattern_in; m_q.delete();
      m_cnt_a = 0; m_cnt_b = 0; m_z = 1'b0;
    end else if (m_armed && x_valid) begin
      m_q.push_back(x);
      hit = tail_hit();
      m_z = hit;
      if (hit) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
        if (!overlap) m_q.delete();
      end
      if (m_q.size() > PW) void'(m_q.pop_front());
    end else begin
      m_z = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("a_z", z_a, m_z);
    chk("a_armed", armed_a, m_armed);
    chk("a_cnt", cnt_a, CE ? m_cnt_a : 0);
    chk("a_sat", sat_a, CE ? (m_cnt_a == 255) : 0);
    chk("b_z", z_b, m_z);
    chk("b_armed", armed_b, m_armed);
    chk("b_cnt", cnt_b, CE ? m_cnt_b : 0);
    chk("b_sat", sat_b, CE ? (m_cnt_b == 3) : 0);
  endtask

  task automatic cyc(input bit ld, input logic [PW-1:0] p, input bit ov,
                     input bit xv, input bit xb);
    load = ld; pattern_in = p; overlap = ov; x_valid = xv; x = xb;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Reset asserted and released between two clock edges.
  task automatic async_rst();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_model();
    chk("rst_z", z_a, 0);
    chk("rst_armed", armed_a, 0);
    chk("rst_cnt", cnt_a, 0);
    #1 reset_n = 1'b1;
  endtask

  task automatic add(input bit ld, input logic [PW-1:0] p, input bit ov,
                     input bit xv, input bit xb, input bit ez, input int ec);
    vec_t v;
    v.ld = ld; v.pat = p; v.ov = ov; v.xv = xv; v.xb = xb; v.ez = ez; v.ecnt = ec;
    tbl.push_back(v);
  endtask

  task automatic add_bits(input logic [PW-1:0] p, input bit ov, input int n,
                          input logic [15:0] bits, input logic [15:0] zs,
                          input int c0);
    int c;
    c = c0;
    for (int i = 0; i < n; i++) begin
      if (zs[n-1-i]) c++;
      add(1'b0, p, ov, 1'b1, bits[n-1-i], zs[n-1-i], c);
    end
  endtask

  initial begin
    logic [PW-1:0] B;
    bit ov_r;
    B = 4'b1011;
    model_reset();

    // reset and idle behaviour
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_z", z_a, 0);
    chk("reset_armed", armed_a, 0);
    chk("reset_cnt", cnt_a, 0);
    chk("reset_sat", sat_b, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      chk("idle_z", z_a, 0);
      chk("idle_armed", armed_a, 0);
    end

    // overlap: 1,0,1,1,0,1,1
    add(1'b1, B, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add_bits(B, 1'b1, 7, 16'b1011011, 16'b0001001, 0);
    // non-overlap: 1,0,1,1,0,1,1
    add(1'b1, B, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add_bits(B, 1'b0, 7, 16'b1011011, 16'b0001000, 0);
    // non-overlap: 1,0,1,1,1,0,1,1
    add(1'b1, B, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add_bits(B, 1'b0, 8, 16'b10111011, 16'b00010001, 0);
    // valid gaps between bits
    add(1'b1, B, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(1'b0, B, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    add(1'b0, B, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    add(1'b0, B, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(1'b0, B, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(1'b0, B, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    add(1'b0, B, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    add(1'b0, B, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b0, B, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    add(1'b0, B, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    // load coincident with the 3rd valid bit drops that bit
    add(1'b1, B, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add_bits(B, 1'b1, 2, 16'b10, 16'b00, 0);
    add(1'b1, B, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    add_bits(B, 1'b1, 4, 16'b1011, 16'b0001, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].ld, tbl[i].pat, tbl[i].ov, tbl[i].xv, tbl[i].xb);
      chk("tbl_z", z_a, tbl[i].ez);
      chk("tbl_cnt", cnt_a, CE ? tbl[i].ecnt : 0);
    end

    // saturation on the narrow counter, back-to-back matches
    cyc(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1);
      chk("sat_z", z_b, (i >= 3) ? 1 : 0);
      chk("sat_cnt", cnt_b, CE ? ((i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2)) : 0);
    end
    chk("sat_flag", sat_b, CE ? 1 : 0);
    cyc(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    chk("sat_hold_z", z_b, 0);
    chk("sat_hold_cnt", cnt_b, CE ? 3 : 0);

    // async reset mid-stream, after 3 bits of a pending 1011
    cyc(1'b1, B, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, B, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, B, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, B, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, B, 1'b1, 1'b1, 1'b1);
    chk("pre_rst_z", z_a, 1);
    cyc(1'b0, B, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, B, 1'b1, 1'b1, 1'b1);
    async_rst();
    cyc(1'b0, B, 1'b1, 1'b1, 1'b1);
    chk("post_rst_z", z_a, 0);
    chk("post_rst_armed", armed_a, 0);

    // randomized stimulus against the model
    ov_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit ld;
      ld = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) ov_r = ~ov_r;
      cyc(ld, PW'($urandom), ov_r, ($urandom_range(0, 3) != 0), 1'($urandom));
      if ($urandom_range(0, 399) == 0) async_rst();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector. Successor to the fixed-pattern single-bit FSM detector.
- Pattern width is a parameter. The pattern is loaded at run time.
- Overlapping and non-overlapping detection are selectable. Input is qualified by a valid strobe.
- Sits after a serial bit source. Produces a registered one-cycle match pulse and an optional match counter.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
CNT_W, 8, match counter width (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
load  input  1  capture pattern_in; clears history, fill and count
pattern_in  input  PAT_W  pattern to detect; bit PAT_W-1 is the oldest (first-received) bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle
x_valid  input  1  x carries a valid bit this cycle
x  input  1  serial data bit
z  output  1  match pulse, one cycle wide
armed  output  1  a pattern is loaded and the detector is running
match_count  output  CNT_W  saturating number of matches since load/reset
count_sat  output  1  match_count has reached all-ones

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, history=0, fill=0, pattern register=0.
  - z=0, armed=0, match_count=0, count_sat=0.
  - Takes effect immediately, including mid-stream.
  - First load is possible on the first clk edge with reset_n high.
- States:
  - IDLE: x/x_valid ignored, z=0, armed=0.
  - RUN: detection active, armed=1.
  - IDLE->RUN on load=1. RUN->RUN on load=1 (reload). RUN has no exit except reset.
- Load (any state, rising edge with load=1):
  - pattern register <= pattern_in; history <= 0; fill <= 0; match_count <= 0; count_sat <= 0; z <= 0.
  - load=1 and x_valid=1 in the same cycle: load wins, the bit is discarded.
- Shift (RUN, x_valid=1, load=0):
  - history <= {history[PAT_W-2:0], x}.
  - fill <= min(fill+1, PAT_W); fill is log2 wide enough to hold PAT_W.
  - x_valid=0: history, fill and count hold; z <= 0.
- Match condition, evaluated on the incoming bit:
  - (fill >= PAT_W-1) and ({history[PAT_W-2:0], x} == pattern register).
  - On match, next cycle z=1 for exactly one clk. Latency: the edge that samples the completing bit sets z; z clears on the following edge unless another match occurs.
  - Back-to-back matches (overlap mode, e.g. pattern all-ones) hold z high on consecutive cycles, one cycle per match.
- Overlap=1: after a match, fill stays saturated at PAT_W and history is kept, so a suffix can start the next match.
- Overlap=0: on a match, fill <= 0. The shifted history is still written, but a new match needs PAT_W fresh bits.
- Overlap toggled mid-stream: takes effect at the next match; no other side effect.
- Counter:
  - match_count increments by 1 on each match and saturates at 2^CNT_W-1, with no wrap.
  - count_sat=1 while match_count is all-ones; cleared only by load or reset.
- Pattern of all zeros is legal. It matches after PAT_W zero bits, since fill gating prevents false matches from the reset history.

Optional Feature:
SEQ_DET_COUNT_EN
- Defined: match_count and count_sat behave as above.
- Undefined: counter logic is not built; match_count and count_sat are tied to 0. Ports remain present. z and armed are unchanged.

Test Plan:
- Reset/idle: reset_n low 2 cycles, then x_valid=1 with x=1 for 8 cycles, no load -> z=0, armed=0, match_count=0 throughout.
- Overlap: PAT_W=4, load 4'b1011, overlap=1, stream 1,0,1,1,0,1,1 (x_valid=1 every cycle) -> z pulses the cycle after bits 4 and 7; match_count=2.
- Non-overlap: same pattern, overlap=0, stream 1,0,1,1,0,1,1 -> single z pulse after bit 4, match_count=1. Stream 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8.
- Valid gaps and load priority:
  - Stream 1011 with x_valid=0 bubbles between bits -> exactly one z pulse, one cycle after the 4th valid bit.
  - load=1 coincident with the 3rd valid bit -> that bit is dropped, fill=0, count cleared.
- Saturation: CNT_W=2, pattern 4'b1111, overlap=1, seven 1s -> z high 4 consecutive cycles; match_count stops at 3; count_sat=1.
- Async reset mid-stream: assert reset_n low between clk edges after bit 3 of 1011 -> z, armed, match_count go 0 immediately. Finishing the pattern without reload gives no match.
